// File: rtl/inst_fetch_sequencer.sv
// ============================================================================
//  Module      : inst_fetch_sequencer
//  Description : Fetches instructions from program memory at the interpreter
//                PC, issues each one with a one-cycle start pulse and waits
//                for done. Handles run / single-step / halt-word control.
//                Optional done-wait watchdog: define FETCH_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                INST_W      = 16,
  parameter logic [INST_W-1:0] HALT_WORD   = 16'hFFFF,
  parameter int                WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic [INST_W-1:0] inst,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       inst_count,
  output logic              fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t state;

`ifdef FETCH_WATCHDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      inst       <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      inst_count <= 16'd0;
`ifdef FETCH_WATCHDOG_EN
      fault      <= 1'b0;
      wdog_cnt   <= '0;
`endif
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run || step) begin
            state    <= FETCH;
            mem_addr <= pc_in;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
          end
        end

        FETCH: begin
          if (mem_valid) begin
            mem_rd <= 1'b0;
            if (mem_data == HALT_WORD) begin
              state  <= HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              inst  <= mem_data;
              start <= 1'b1;
              state <= ISSUE;
            end
          end
        end

        // done is deliberately not looked at here, so a level left high by
        // the previous instruction cannot complete this one.
        ISSUE: begin
          state <= EXEC;
`ifdef FETCH_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
        end

        EXEC: begin
          if (done) begin
            inst_count <= inst_count + 16'd1;
            if (run) begin
              state    <= FETCH;
              mem_addr <= pc_in;
              mem_rd   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
`ifdef FETCH_WATCHDOG_EN
          else if (wdog_cnt == WDOG_LAST) begin
            fault  <= 1'b1;
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end

        HALTED: begin
          state <= HALTED;
        end

        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_sequencer.sv
// Directed, table-driven bench for inst_fetch_sequencer with a latency-
// programmable memory responder and a delay-programmable interpreter responder.
`default_nettype none

module tb_inst_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  pc_in;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data = 16'h0;
  logic        mem_valid = 1'b0;
  logic [15:0] inst;
  logic        start;
  logic        done = 1'b0;
  logic        busy;
  logic        halted;
  logic [15:0] inst_count;
  logic        fault;

  inst_fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .pc_in      (pc_in),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .inst       (inst),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .halted     (halted),
    .inst_count (inst_count),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [15:0] mem [256];
  int          lat = 1;
  int          dly = 1;
  bit          done_hold = 1'b0;
  bit          done_never = 1'b0;
  bit          auto_pc = 1'b0;
  logic [7:0]  pc_man = 8'h0;
  logic [7:0]  pc_auto = 8'h0;
  assign pc_in = auto_pc ? pc_auto : pc_man;

  bit          pend = 1'b0;
  int          mcnt = 0;
  logic [7:0]  req = 8'h0;

  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (pend) begin
      if (mcnt <= 1) begin
        mem_valid <= 1'b1;
        mem_data  <= mem[req];
        pend      <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end else if (mem_rd && !mem_valid && rst_n) begin
      req <= mem_addr;
      if (lat <= 1) begin
        mem_valid <= 1'b1;
        mem_data  <= mem[mem_addr];
      end else begin
        pend <= 1'b1;
        mcnt <= lat - 1;
      end
    end
  end

  int dcnt = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      done    <= 1'b0;
      dcnt    <= 0;
      pc_auto <= 8'h0;
    end else if (start) begin
      if (auto_pc) pc_auto <= pc_auto + 8'd1;
      if (!done_never) begin
        if (dly <= 1) done <= 1'b1;
        else dcnt <= dly - 1;
      end
    end else if (dcnt == 1) begin
      done <= 1'b1;
      dcnt <= 0;
    end else if (dcnt > 1) begin
      dcnt <= dcnt - 1;
    end else if (done) begin
      done <= 1'b0;
    end
    if (done_hold) done <= 1'b1;
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          n_starts = 0;
  int          rd_cyc = 0;
  int          start_cyc = 0;
  int          prev_start_cyc = 0;
  logic        rd_q = 1'b0;
  logic [15:0] start_log [8];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_q <= mem_rd;
    if (mem_rd && !rd_q) rd_cyc <= cyc;
    if (start) begin
      start_log[n_starts[2:0]] <= inst;
      n_starts       <= n_starts + 1;
      prev_start_cyc <= start_cyc;
      start_cyc      <= cyc;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit check);
    run = 1'b0;
    step = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (check) begin
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_inst", 32'(inst), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", 32'(inst_count), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_start_or_halt(input int s0, input int maxc, input string name);
    int n = 0;
    while (n_starts == s0 && !halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_not_busy(input int maxc, input string name);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_halted(input int maxc, input string name);
    int n = 0;
    while (!halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(halted), 32'd1);
  endtask

  typedef struct {
    logic [15:0] word;
    int          lat;
    int          dly;
    bit          use_step;
    int          exp_starts;
    logic [15:0] exp_inst;
    bit          exp_halted;
    int          exp_count;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int s0;
    logic [7:0] pc;

    for (int a = 0; a < 256; a++) mem[a] = 16'h0;

    vecs[0] = '{16'h0401, 1, 2, 1'b0, 1, 16'h0401, 1'b0, 1, 2};
    vecs[1] = '{16'h5000, 1, 1, 1'b1, 1, 16'h5000, 1'b0, 1, 2};
    vecs[2] = '{16'h1234, 3, 4, 1'b1, 1, 16'h1234, 1'b0, 1, 4};
    vecs[3] = '{16'hFFFF, 2, 1, 1'b1, 0, 16'h0000, 1'b1, 0, 0};
    vecs[4] = '{16'hFFFE, 5, 3, 1'b0, 1, 16'hFFFE, 1'b0, 1, 6};
    vecs[5] = '{16'h00FF, 2, 1, 1'b0, 1, 16'h00FF, 1'b0, 1, 3};

    // single-instruction vectors, each from a fresh reset
    for (int i = 0; i < 6; i++) begin
      do_reset(i == 0);
      pc = 8'(i * 16);
      pc_man = pc;
      mem[pc] = vecs[i].word;
      lat = vecs[i].lat;
      dly = vecs[i].dly;
      s0 = n_starts;
      if (vecs[i].use_step) begin
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
      end else begin
        run = 1'b1;
      end
      wait_start_or_halt(s0, 40, $sformatf("v%0d_wait", i));
      run = 1'b0;
      wait_not_busy(40, $sformatf("v%0d_busy", i));
      chk($sformatf("v%0d_starts", i), 32'(n_starts - s0), 32'(vecs[i].exp_starts));
      chk($sformatf("v%0d_inst", i), 32'(inst), 32'(vecs[i].exp_inst));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
      chk($sformatf("v%0d_count", i), 32'(inst_count), 32'(vecs[i].exp_count));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(pc));
      chk($sformatf("v%0d_rd", i), 32'(mem_rd), 32'd0);
      if (vecs[i].exp_starts > 0)
        chk($sformatf("v%0d_latency", i), 32'(start_cyc - rd_cyc), 32'(vecs[i].exp_lat));
    end

    // free-run program ending in the halt word
    do_reset(1'b0);
    mem[0] = 16'h0401; mem[1] = 16'h0C01; mem[2] = 16'h4000; mem[3] = 16'hFFFF;
    lat = 1; dly = 2; auto_pc = 1'b1;
    s0 = n_starts;
    run = 1'b1;
    wait_halted(100, "prog_halt_wait");
    repeat (3) @(negedge clk);
    chk("prog_starts", 32'(n_starts - s0), 32'd3);
    chk("prog_inst0", 32'(start_log[(s0 + 0) & 7]), 32'h0401);
    chk("prog_inst1", 32'(start_log[(s0 + 1) & 7]), 32'h0C01);
    chk("prog_inst2", 32'(start_log[(s0 + 2) & 7]), 32'h4000);
    chk("prog_count", 32'(inst_count), 32'd3);
    chk("prog_inst_hold", 32'(inst), 32'h4000);
    chk("prog_busy", 32'(busy), 32'd0);
    chk("prog_addr", 32'(mem_addr), 32'd3);
    run = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    chk("prog_halt_sticky", 32'(halted), 32'd1);
    chk("prog_halt_no_fetch", 32'(mem_rd), 32'd0);
    auto_pc = 1'b0;

    // done held high: completes on first EXEC cycle, never during ISSUE
    do_reset(1'b0);
    mem[0] = 16'h0401; mem[1] = 16'h0C01; mem[2] = 16'hFFFF;
    lat = 1; auto_pc = 1'b1; done_hold = 1'b1;
    s0 = n_starts;
    run = 1'b1;
    wait_halted(100, "hold_halt_wait");
    chk("hold_starts", 32'(n_starts - s0), 32'd2);
    chk("hold_count", 32'(inst_count), 32'd2);
    chk("hold_spacing", 32'(start_cyc - prev_start_cyc), 32'd4);
    chk("hold_last_inst", 32'(inst), 32'h0C01);
    run = 1'b0; done_hold = 1'b0; auto_pc = 1'b0;

    // single step; a second step during EXEC is dropped
    do_reset(1'b0);
    pc_man = 8'h20; mem[8'h20] = 16'h5000;
    lat = 1; dly = 4;
    s0 = n_starts;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_start_or_halt(s0, 20, "step_wait");
    @(negedge clk);
    chk("step_busy_exec", 32'(busy), 32'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_not_busy(20, "step_idle");
    repeat (5) @(negedge clk);
    chk("step_starts", 32'(n_starts - s0), 32'd1);
    chk("step_count", 32'(inst_count), 32'd1);
    chk("step_inst", 32'(inst), 32'h5000);
    chk("step_rd", 32'(mem_rd), 32'd0);

    // reset in the third FETCH cycle of a 5-cycle-latency read
    pc_man = 8'h30; mem[8'h30] = 16'h1111;
    lat = 5;
    s0 = n_starts;
    run = 1'b1;
    begin
      int n = 0;
      while (!mem_rd && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("mrst_fetch_wait", 32'(mem_rd), 32'd1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("mrst_rd", 32'(mem_rd), 32'd0);
    chk("mrst_addr", 32'(mem_addr), 32'd0);
    chk("mrst_inst", 32'(inst), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_count", 32'(inst_count), 32'd0);
    chk("mrst_halted", 32'(halted), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mrst_late_starts", 32'(n_starts - s0), 32'd0);
    chk("mrst_late_busy", 32'(busy), 32'd0);
    chk("mrst_late_inst", 32'(inst), 32'd0);

    // done never returns
    do_reset(1'b0);
    pc_man = 8'h50; mem[8'h50] = 16'h0401;
    lat = 1; done_never = 1'b1;
    s0 = n_starts;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_start_or_halt(s0, 20, "wdog_start_wait");
`ifdef FETCH_WATCHDOG_EN
    repeat (63) @(negedge clk);
    chk("wdog_before_halted", 32'(halted), 32'd0);
    chk("wdog_before_fault", 32'(fault), 32'd0);
    @(negedge clk);
    chk("wdog_halted", 32'(halted), 32'd1);
    chk("wdog_fault", 32'(fault), 32'd1);
    chk("wdog_count", 32'(inst_count), 32'd0);
    chk("wdog_busy", 32'(busy), 32'd0);
`else
    repeat (100) @(negedge clk);
    chk("nowdog_fault", 32'(fault), 32'd0);
    chk("nowdog_busy", 32'(busy), 32'd1);
    chk("nowdog_halted", 32'(halted), 32'd0);
    chk("nowdog_count", 32'(inst_count), 32'd0);
`endif
    done_never = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch_sequencer.md
Name: inst_fetch_sequencer

Overview:
Clocked front end that fetches 16-bit instructions from program memory at the address given by the interpreter's PC. It presents each instruction on inst with a one-cycle start pulse, then waits for the interpreter's done before fetching the next one. It sits directly upstream of the instruction interpreter, between program memory and inst/start, and owns run/halt/single-step control.

Parameters:
ADDR_W, 8, program address width; matches interpreter PC width
INST_W, 16, instruction width
HALT_WORD, 16'hFFFF, instruction encoding that stops the sequencer without being issued
WDOG_CYCLES, 64, done-wait limit; used only when the optional feature is enabled

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = free-run fetch/issue
step  input  1  one-cycle pulse; fetch/issue exactly one instruction while run=0
pc_in  input  ADDR_W  current PC from interpreter
mem_rd  output  1  fetch request, held until mem_valid
mem_addr  output  ADDR_W  fetch address
mem_data  input  INST_W  fetched word, valid when mem_valid=1
mem_valid  input  1  read data valid; arbitrary latency >=1 cycle
inst  output  INST_W  instruction to interpreter, registered
start  output  1  one-cycle issue pulse to interpreter
done  input  1  interpreter completion, level
busy  output  1  1 in any state except IDLE/HALTED
halted  output  1  1 in HALTED
inst_count  output  16  retired instructions, wraps 16'hFFFF->0
fault  output  1  watchdog fault, sticky (tied 0 if feature disabled)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_rd=0, mem_addr=0, inst=0, start=0, busy=0, halted=0, inst_count=0, fault=0. Reset mid-fetch or mid-execute aborts immediately; a late mem_valid after reset is ignored because the state is IDLE.
- States: IDLE, FETCH, ISSUE, EXEC, HALTED.
- IDLE: if run=1, or step=1 on that edge, go to FETCH; latch mem_addr<=pc_in, mem_rd<=1. run has priority over step when both are 1.
- FETCH: mem_rd and mem_addr held stable. When mem_valid=1: mem_rd<=0.
  - mem_data==HALT_WORD: go to HALTED; no start; inst unchanged; inst_count unchanged.
  - Otherwise: inst<=mem_data and go to ISSUE.
- ISSUE: start=1 for exactly this one cycle; inst stable; go to EXEC.
- EXEC: start=0. Completion is done=1 sampled in any EXEC cycle; the ISSUE cycle is never sampled, so a stale done left high from the previous instruction is ignored. On completion: inst_count+=1 (wraps), then:
  - run=1: go to FETCH with mem_addr<=pc_in sampled that edge.
  - run=0: go to IDLE.
  - A step arriving during a non-IDLE state is dropped.
- HALTED: sticky; only reset exits. run/step are ignored.
- Minimum instruction latency: mem_rd assertion to start = mem latency + 1 cycle. Back-to-back throughput = mem latency + 3 cycles when done returns on the first EXEC cycle.
- inst holds its last issued value through IDLE and HALTED.
- busy=1 in FETCH, ISSUE and EXEC; halted=1 only in HALTED.

Optional Feature:
Macro FETCH_WATCHDOG_EN.
- Defined: an 8-bit-minimum counter clears on entry to EXEC and increments each EXEC cycle without done. When it reaches WDOG_CYCLES, fault<=1 (sticky until reset) and state goes to HALTED; inst_count is not incremented.
- Not defined: no counter; fault is constant 0; EXEC waits indefinitely.

Test Plan:
1. Reset release, run=1, pc_in=0, memory[0]=16'h0401 (latency 1), done returns 2 cycles after start -> mem_addr=0, inst=16'h0401, single start pulse, inst_count=1.
2. Free-run over program 0401, 0C01, 4000, FFFF with pc_in incrementing 0..3 -> exactly 3 start pulses with inst 0401, 0C01, 4000; halted=1; inst_count=3; no start for FFFF.
3. run=0, step pulse, memory word 16'h5000 -> one fetch and one start with inst=5000, then IDLE with busy=0. A second step issued during EXEC is dropped: still one start only.
4. done held high continuously -> each instruction still completes no earlier than the first EXEC cycle; exactly one start per instruction; inst_count increments once per instruction.
5. Memory latency 5 cycles, then rst_n pulled low in the 3rd FETCH cycle -> all outputs return to reset values immediately; the late mem_valid causes no start.
6. With FETCH_WATCHDOG_EN, WDOG_CYCLES=64, done never asserted -> fault=1 and halted=1 exactly 64 EXEC cycles after start; inst_count=0. Without the macro, fault stays 0 and busy stays 1.
